// File: rtl/ms_timer_bank.sv
// ms_timer_bank: multi-channel millisecond timer bank with integrated tick prescaler.
// Each channel counts up or down on prescaler ticks and supports clear, load,
// lap capture and a one-cycle expiry pulse on down-count terminal.
// Optional feature macro: MS_TIMER_AUTORELOAD_EN (periodic down-count reload);
// when undefined, a down-counting channel is one-shot and holds at zero.
module ms_timer_bank #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NUM_CH  = 2,
  parameter int WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH-1:0]       cap,
  output logic                    tick,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH*WIDTH-1:0] lap,
  output logic [NUM_CH-1:0]       expired
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;

  // Prescaler walks 0..DIV-1; tick is the registered decode of the last value,
  // so the first tick lands DIV cycles after reset release.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (presc == PRESC_LAST);
      presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] lap_q;
    logic             exp_q;
    logic [WIDTH-1:0] reload_val;

    assign reload_val = load_val[i*WIDTH +: WIDTH];

    // Channel update: clr beats load beats tick-advance; lap capture runs in
    // parallel and always sees the count as it was before this edge.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lap_q <= '0;
        exp_q <= 1'b0;
      end else begin
        exp_q <= 1'b0;
        if (cap[i]) lap_q <= cnt_q;
        if (clr[i]) begin
          cnt_q <= '0;
        end else if (load[i]) begin
          cnt_q <= reload_val;
        end else if (tick && en[i]) begin
          if (!mode[i]) begin
            cnt_q <= cnt_q + WIDTH'(1);
          end else if (cnt_q > WIDTH'(1)) begin
            cnt_q <= cnt_q - WIDTH'(1);
          end else if (cnt_q == WIDTH'(1)) begin
            exp_q <= 1'b1;
`ifdef MS_TIMER_AUTORELOAD_EN
            cnt_q <= reload_val;
`else
            cnt_q <= '0;
`endif
          end
        end
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_q;
    assign lap[i*WIDTH +: WIDTH]   = lap_q;
    assign expired[i]              = exp_q;
  end

endmodule

// File: tb/tb_ms_timer_bank.sv
// Testbench for ms_timer_bank: directed stimulus, a cycle-level behavioural
// model compared every cycle, plus hand-computed literal expectations.
module tb_ms_timer_bank;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int NUM_CH  = 2;
  localparam int WIDTH   = 32;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       en, clr, mode, load, cap;
  logic [NUM_CH*WIDTH-1:0] load_val;
  logic                    tick;
  logic [NUM_CH*WIDTH-1:0] count, lap;
  logic [NUM_CH-1:0]       expired;

  ms_timer_bank #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CH(NUM_CH), .WIDTH(WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .load(load),
    .load_val(load_val), .cap(cap), .tick(tick), .count(count), .lap(lap),
    .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tick timing follows from the number of clock edges since reset release:
  // a tick cycle is every DIV-th cycle after release.
  int               cyc = 0;
  bit               m_valid = 0;
  bit               m_tick = 0;
  logic [WIDTH-1:0] m_count [NUM_CH];
  logic [WIDTH-1:0] m_lap   [NUM_CH];
  bit               m_exp   [NUM_CH];

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      m_tick = 0;
      m_valid = 1;
      for (int c = 0; c < NUM_CH; c++) begin
        m_count[c] = '0;
        m_lap[c] = '0;
        m_exp[c] = 0;
      end
    end else if (m_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        logic [WIDTH-1:0] lv;
        lv = load_val[c*WIDTH +: WIDTH];
        m_exp[c] = 0;
        if (cap[c]) m_lap[c] = m_count[c];
        if (clr[c]) m_count[c] = '0;
        else if (load[c]) m_count[c] = lv;
        else if (m_tick && en[c]) begin
          if (!mode[c]) m_count[c] = m_count[c] + 1;
          else if (m_count[c] >= 2) m_count[c] = m_count[c] - 1;
          else if (m_count[c] == 1) begin
            m_exp[c] = 1;
`ifdef MS_TIMER_AUTORELOAD_EN
            m_count[c] = lv;
`else
            m_count[c] = '0;
`endif
          end
        end
      end
      cyc = cyc + 1;
      m_tick = (cyc % DIV) == 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [NUM_CH*WIDTH-1:0] ec, el;
      logic [NUM_CH-1:0]       ee;
      for (int c = 0; c < NUM_CH; c++) begin
        ec[c*WIDTH +: WIDTH] = m_count[c];
        el[c*WIDTH +: WIDTH] = m_lap[c];
        ee[c] = m_exp[c];
      end
      check("model_tick", 64'(tick), 64'(m_tick));
      check("model_count", 64'(count), 64'(ec));
      check("model_lap", 64'(lap), 64'(el));
      check("model_expired", 64'(expired), 64'(ee));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Advance to the negedge inside the next expected tick cycle (bounded).
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_tick && n < 3 * DIV);
    check("wait_tick_bound", 64'(m_tick), 64'(1));
  endtask

  // Land on the cycle right after a tick, so the next DIV-1 cycles are quiet.
  task automatic sync();
    wait_tick();
    @(negedge clk);
  endtask

  function automatic logic [WIDTH-1:0] cnt_of(input int c);
    return count[c*WIDTH +: WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] lap_of(input int c);
    return lap[c*WIDTH +: WIDTH];
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    en = '0; clr = '0; mode = '0; load = '0; cap = '0; load_val = '0;

    // Reset then idle: everything zero, tick in cycle 10, 20 after release.
    repeat (3) @(negedge clk);
    check("reset_tick", 64'(tick), 64'(0));
    check("reset_count", 64'(count), 64'(0));
    check("reset_lap", 64'(lap), 64'(0));
    check("reset_expired", 64'(expired), 64'(0));
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      check($sformatf("idle_tick_c%0d", k), 64'(tick), 64'((k % DIV) == 0));
    end

    // ch0 up for 5 ticks, then clr+load together: clr wins.
    sync();
    en[0] = 1'b1; mode[0] = 1'b0;
    repeat (5) wait_tick();
    @(negedge clk);
    check("ch0_up5", 64'(cnt_of(0)), 64'd5);
    en[0] = 1'b0; clr[0] = 1'b1; load[0] = 1'b1;
    load_val[0 +: WIDTH] = 32'd7;
    @(negedge clk);
    clr[0] = 1'b0; load[0] = 1'b0;
    check("ch0_clr_over_load", 64'(cnt_of(0)), 64'd0);

    // ch1 down from 3.
    sync();
    load[1] = 1'b1; load_val[WIDTH +: WIDTH] = 32'd3; mode[1] = 1'b1; en[1] = 1'b1;
    @(negedge clk);
    load[1] = 1'b0;
    check("ch1_loaded", 64'(cnt_of(1)), 64'd3);
    wait_tick(); @(negedge clk);
    check("ch1_down_2", 64'(cnt_of(1)), 64'd2);
    check("ch1_noexp_2", 64'(expired[1]), 64'd0);
    wait_tick(); @(negedge clk);
    check("ch1_down_1", 64'(cnt_of(1)), 64'd1);
    wait_tick(); @(negedge clk);
`ifdef MS_TIMER_AUTORELOAD_EN
    check("ch1_reload_3", 64'(cnt_of(1)), 64'd3);
`else
    check("ch1_down_0", 64'(cnt_of(1)), 64'd0);
`endif
    check("ch1_exp_pulse", 64'(expired[1]), 64'd1);
    @(negedge clk);
    check("ch1_exp_one_cycle", 64'(expired[1]), 64'd0);
    wait_tick(); @(negedge clk);
`ifdef MS_TIMER_AUTORELOAD_EN
    check("ch1_after_reload", 64'(cnt_of(1)), 64'd2);
`else
    check("ch1_hold_0", 64'(cnt_of(1)), 64'd0);
`endif
    check("ch1_no_second_exp", 64'(expired[1]), 64'd0);
    en[1] = 1'b0;

    // Up-count wrap at all-ones: back to 0, no expiry.
    sync();
    mode[0] = 1'b0; load[0] = 1'b1; load_val[0 +: WIDTH] = 32'hFFFF_FFFF; en[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    wait_tick(); @(negedge clk);
    check("ch0_wrap", 64'(cnt_of(0)), 64'd0);
    check("ch0_wrap_noexp", 64'(expired[0]), 64'd0);

    // Lap capture in the tick cycle with count0 = 4.
    sync();
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    repeat (5) wait_tick();
    check("ch0_pre_cap", 64'(cnt_of(0)), 64'd4);
    cap[0] = 1'b1;
    @(negedge clk);
    cap[0] = 1'b0;
    check("ch0_lap_4", 64'(lap_of(0)), 64'd4);
    check("ch0_after_cap_5", 64'(cnt_of(0)), 64'd5);
    en[0] = 1'b0; clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    check("ch0_clr_after_cap", 64'(cnt_of(0)), 64'd0);
    check("ch0_lap_holds", 64'(lap_of(0)), 64'd4);

    // Reset mid-countdown with count1 = 2; tick realigns to release.
    sync();
    load[1] = 1'b1; load_val[WIDTH +: WIDTH] = 32'd5; mode[1] = 1'b1; en[1] = 1'b1;
    @(negedge clk);
    load[1] = 1'b0;
    repeat (3) wait_tick();
    @(negedge clk);
    check("ch1_mid_2", 64'(cnt_of(1)), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_reset_tick", 64'(tick), 64'(0));
    check("mid_reset_count", 64'(count), 64'(0));
    check("mid_reset_lap", 64'(lap), 64'(0));
    check("mid_reset_expired", 64'(expired), 64'(0));
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_tick_c%0d", k), 64'(tick), 64'(k == DIV));
    end
    en = '0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
